// File: rtl/result_serializer.sv
// Captures 25 compressor result bits on start and shifts them out one per cycle.
// Define RESULT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module result_serializer #(
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dst0,
   input  logic       dst1,
   input  logic       dst2,
   input  logic       dst3,
   input  logic       dst4,
   input  logic       dst5,
   input  logic       dst6,
   input  logic       dst7,
   input  logic       dst8,
   input  logic       dst9,
   input  logic       dst10,
   input  logic       dst11,
   input  logic       dst12,
   input  logic       dst13,
   input  logic       dst14,
   input  logic       dst15,
   input  logic       dst16,
   input  logic       dst17,
   input  logic       dst18,
   input  logic       dst19,
   input  logic       dst20,
   input  logic       dst21,
   input  logic       dst22,
   input  logic       dst23,
   input  logic       dst24,
   input  logic       start,
   output logic       sout,
   output logic       sout_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_cnt
);

`ifdef RESULT_SERIALIZER_PARITY_EN
   localparam int unsigned FRAME_LEN = 26;
`else
   localparam int unsigned FRAME_LEN = 25;
`endif
   localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e      state_q,     state_d;
   logic [24:0] shadow_q,    shadow_d;
   logic [4:0]  bit_cnt_q,   bit_cnt_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic [24:0] dst_w;
`ifdef RESULT_SERIALIZER_PARITY_EN
   logic        parity_q,    parity_d;
`endif

   assign dst_w = {dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17, dst16,
                   dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,  dst7,
                   dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

   assign frame_cnt = frame_cnt_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      shadow_d    = shadow_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
`ifdef RESULT_SERIALIZER_PARITY_EN
      parity_d    = parity_q;
`endif
      sout        = 1'b0;
      sout_valid  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               shadow_d  = dst_w;
               bit_cnt_d = 5'd0;
`ifdef RESULT_SERIALIZER_PARITY_EN
               parity_d  = ^dst_w;
`endif
            end
         end
         SHIFT: begin
            sout_valid = 1'b1;
            busy       = 1'b1;
            // The shadow register shifts toward the output end, so the next bit is always at the edge.
            if (LSB_FIRST != 0) begin
               sout     = shadow_q[0];
               shadow_d = {1'b0, shadow_q[24:1]};
            end else begin
               sout     = shadow_q[24];
               shadow_d = {shadow_q[23:0], 1'b0};
            end
`ifdef RESULT_SERIALIZER_PARITY_EN
            if (bit_cnt_q == 5'd25) sout = parity_q;
`endif
            if (bit_cnt_q == LAST_BIT) begin
               done        = 1'b1;
               state_d     = IDLE;
               bit_cnt_d   = 5'd0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               bit_cnt_d   = bit_cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow register is a plain register, not a memory, so clearing it on reset is cheap.
         state_q     <= IDLE;
         shadow_q    <= '0;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef RESULT_SERIALIZER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: an LSB-first and an MSB-first instance share stimulus
// and are compared cycle by cycle against a frame-level reference model.
module tb_result_serializer;

`ifdef RESULT_SERIALIZER_PARITY_EN
   localparam int F = 26;
`else
   localparam int F = 25;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [24:0] dst;
   logic        sout_o  [2];
   logic        valid_o [2];
   logic        busy_o  [2];
   logic        done_o  [2];
   logic [7:0]  cnt_o   [2];

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   result_serializer #(.LSB_FIRST(1)) u_lsb (
      .clk(clk), .rst(rst),
      .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),
      .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),
      .dst10(dst[10]), .dst11(dst[11]), .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]),
      .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
      .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]), .dst24(dst[24]),
      .start(start), .sout(sout_o[0]), .sout_valid(valid_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .frame_cnt(cnt_o[0])
   );

   result_serializer #(.LSB_FIRST(0)) u_msb (
      .clk(clk), .rst(rst),
      .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),   .dst4(dst[4]),
      .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),   .dst8(dst[8]),   .dst9(dst[9]),
      .dst10(dst[10]), .dst11(dst[11]), .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]),
      .dst15(dst[15]), .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
      .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]), .dst24(dst[24]),
      .start(start), .sout(sout_o[1]), .sout_valid(valid_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .frame_cnt(cnt_o[1])
   );

   // Reference: bit i of a frame carrying value v; d=0 is LSB-first, d=1 is MSB-first.
   function automatic logic exp_bit(input logic [24:0] v, input int i, input int d);
      if (i >= 25) return ^v;
      if (d == 0) return v[i];
      return v[24 - i];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in an idle cycle; drives one frame and checks every cycle plus the idle cycle after it.
   // smode: start during the frame 0=low 1=random 2=high; noise: 0=none 1=random dst 2=dst->0 mid-frame.
   task automatic run_frame(input logic [24:0] v, input int smode, input int noise, input string tag);
      dst   = v;
      start = 1'b1;
      tick();
      for (int i = 0; i < F; i++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (sout_o[d] !== exp_bit(v, i, d) || valid_o[d] !== 1'b1 || busy_o[d] !== 1'b1 ||
                done_o[d] !== logic'(i == F - 1) || cnt_o[d] !== exp_cnt[7:0]) begin
               errors++;
               $display("FAIL %s dut%0d bit%0d: got sout=%b valid=%b busy=%b done=%b cnt=%0d, want sout=%b valid=1 busy=1 done=%b cnt=%0d",
                        tag, d, i, sout_o[d], valid_o[d], busy_o[d], done_o[d], cnt_o[d],
                        exp_bit(v, i, d), logic'(i == F - 1), exp_cnt[7:0]);
            end
         end
         start = (smode == 0) ? 1'b0 : (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (noise == 1) dst = 25'($urandom);
         else if (noise == 2 && i == 12) dst = 25'h0;
         tick();
      end
      exp_cnt = (exp_cnt + 1) % 256;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({sout_o[d], valid_o[d], busy_o[d], done_o[d]} !== 4'b0000 || cnt_o[d] !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL %s dut%0d idle-after: got sout/valid/busy/done=%b%b%b%b cnt=%0d, want 0000 cnt=%0d",
                     tag, d, sout_o[d], valid_o[d], busy_o[d], done_o[d], cnt_o[d], exp_cnt[7:0]);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      dst   = 25'($urandom);
      tick();
      tick();
      rst     = 1'b0;
      exp_cnt = 0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({sout_o[d], valid_o[d], busy_o[d], done_o[d]} !== 4'b0000 || cnt_o[d] !== 8'd0) begin
            errors++;
            $display("FAIL reset dut%0d: got sout/valid/busy/done=%b%b%b%b cnt=%0d, want 0000 cnt=0",
                     d, sout_o[d], valid_o[d], busy_o[d], done_o[d], cnt_o[d]);
         end
      end
   endtask

   task automatic test_single_bit();
      run_frame(25'h0000001, 0, 0, "single_bit");
   endtask

   task automatic test_alternating();
      run_frame(25'h1555555, 0, 2, "alternating");
   endtask

   task automatic test_random_frames();
      for (int n = 0; n < 6; n++) run_frame(25'($urandom), 1, 1, "random");
   endtask

   task automatic test_back_to_back();
      test_reset();
      for (int n = 0; n < 4; n++) run_frame(25'($urandom), 2, 1, "back_to_back");
   endtask

   task automatic test_abort();
      logic [24:0] v;
      test_reset();
      v     = 25'($urandom);
      dst   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (sout_o[d] !== exp_bit(v, i, d) || valid_o[d] !== 1'b1 || done_o[d] !== 1'b0) begin
               errors++;
               $display("FAIL abort_pre dut%0d bit%0d: got sout=%b valid=%b done=%b, want sout=%b valid=1 done=0",
                        d, i, sout_o[d], valid_o[d], done_o[d], exp_bit(v, i, d));
            end
         end
         if (i < 9) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sout_o[d], valid_o[d], busy_o[d], done_o[d]} !== 4'b0000 || cnt_o[d] !== 8'd0) begin
               errors++;
               $display("FAIL abort_post dut%0d cycle%0d: got sout/valid/busy/done=%b%b%b%b cnt=%0d, want 0000 cnt=0",
                        d, 11 + c, sout_o[d], valid_o[d], busy_o[d], done_o[d], cnt_o[d]);
            end
         end
         tick();
      end
      run_frame(25'($urandom), 0, 1, "after_abort");
   endtask

   task automatic test_reset_priority();
      test_reset();
      rst   = 1'b1;
      start = 1'b1;
      dst   = 25'($urandom);
      tick();
      rst   = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sout_o[d], valid_o[d], busy_o[d], done_o[d]} !== 4'b0000 || cnt_o[d] !== 8'd0) begin
               errors++;
               $display("FAIL rst_priority dut%0d cycle%0d: got sout/valid/busy/done=%b%b%b%b cnt=%0d, want 0000 cnt=0",
                        d, c, sout_o[d], valid_o[d], busy_o[d], done_o[d], cnt_o[d]);
            end
         end
         tick();
      end
   endtask

   task automatic test_counter_wrap();
      test_reset();
      for (int n = 0; n < 256; n++) run_frame(25'($urandom), 1, 1, "wrap");
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (cnt_o[d] !== 8'd0) begin
            errors++;
            $display("FAIL wrap_final dut%0d: got cnt=%0d, want 0", d, cnt_o[d]);
         end
      end
   endtask

`ifdef RESULT_SERIALIZER_PARITY_EN
   task automatic test_parity();
      run_frame(25'h0000007, 0, 0, "parity_odd");
      run_frame(25'h0000003, 0, 0, "parity_even");
   endtask
`endif

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      dst   = 25'h0;
      test_reset();
      test_single_bit();
      test_alternating();
      test_random_frames();
`ifdef RESULT_SERIALIZER_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_abort();
      test_reset_priority();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
